// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : multi-cycle controller feeding an external 16-bit ALU from
//                 an 8x16 register file (fetch A, fetch B, execute, write back)
// Revision      : 1.0
// ============================================================================
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rn,
  input  logic [2:0]  cmd_rm,
  input  logic        cmd_isimm,
  input  logic [15:0] cmd_imm,
  input  logic        cmd_nowb,
  output logic        busy,
  output logic        done,
  output logic        z_flag,
  output logic [15:0] alu_ain,
  output logic [15:0] alu_bin,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rn_q, rn_d;
  logic [2:0]  rm_q, rm_d;
  logic        nowb_q, nowb_d;
  logic [15:0] c_q, c_d;
  logic        z_q, z_d;
  logic [15:0] ain_q, ain_d;
  logic [15:0] bin_q, bin_d;
  logic [1:0]  aop_q, aop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    nowb_d  = nowb_q;
    c_d     = c_q;
    z_d     = z_q;
    ain_d   = ain_q;
    bin_d   = bin_q;
    aop_d   = aop_q;
    rf_d    = rf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = cmd_op;
          rd_d   = cmd_rd;
          rn_d   = cmd_rn;
          rm_d   = cmd_rm;
          nowb_d = cmd_nowb;
          if (cmd_isimm) begin
            c_d     = cmd_imm;
            state_d = S_WB;
          end else begin
            state_d = S_RDA;
          end
        end
      end
      S_RDA: begin
        ain_d   = rf_q[rn_q];
        aop_d   = op_q;
        state_d = S_RDB;
      end
      S_RDB: begin
        bin_d   = rf_q[rm_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d     = alu_out;
        z_d     = alu_z;
        state_d = S_WB;
      end
      S_WB: begin
        if (!nowb_q) rf_d[rd_q] = c_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rd_q    <= 3'd0;
      rn_q    <= 3'd0;
      rm_q    <= 3'd0;
      nowb_q  <= 1'b0;
      c_q     <= 16'h0000;
      z_q     <= 1'b0;
      ain_q   <= 16'h0000;
      bin_q   <= 16'h0000;
      aop_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      nowb_q  <= nowb_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
      aop_q   <= aop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign z_flag   = z_q;
  assign alu_ain  = ain_q;
  assign alu_bin  = bin_q;
  assign alu_op   = aop_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed + randomized bench with a register-file model
// Revision         : 1.0
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic        cmd_isimm;
  logic [15:0] cmd_imm;
  logic        cmd_nowb;
  logic        busy, done, z_flag;
  logic [15:0] alu_ain, alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_rf [8];
  logic        model_z;

  always #5 clk = ~clk;

  // Stand-in for the team ALU sitting between the alu_* ports.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  alu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_isimm(cmd_isimm), .cmd_imm(cmd_imm), .cmd_nowb(cmd_nowb),
    .busy(busy), .done(done), .z_flag(z_flag),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    int unsigned r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 65536;
      2'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
      2'd2:    r = a & b;
      default: r = 65535 - int'(b);
    endcase
    return r[15:0];
  endfunction

  task automatic scramble_fields();
    cmd_op    = 2'($urandom);
    cmd_rd    = 3'($urandom);
    cmd_rn    = 3'($urandom);
    cmd_rm    = 3'($urandom);
    cmd_isimm = 1'($urandom);
    cmd_imm   = 16'($urandom);
    cmd_nowb  = 1'($urandom);
  endtask

  // Only called while idle with start low; re-aligns to posedge+1 afterwards.
  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp_v);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp_v);
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 8; i++) check_reg(tag, 3'(i), model_rf[i]);
    tick();
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic isimm, input logic [15:0] imm,
                         input logic nowb, input logic poke);
    logic [15:0] exp_c;
    logic        exp_z;
    logic [15:0] a, b;
    int          n;
    logic        seen;
    a     = model_rf[rn];
    b     = model_rf[rm];
    exp_c = isimm ? imm : ref_result(op, a, b);
    exp_z = isimm ? model_z : (exp_c == 16'h0000);

    dbg_addr  = rd;
    start     = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rn    = rn;
    cmd_rm    = rm;
    cmd_isimm = isimm;
    cmd_imm   = imm;
    cmd_nowb  = nowb;
    tick();
    start = 1'b0;
    scramble_fields();
    check("busy_after_accept", busy, 1);

    n    = 0;
    seen = 1'b0;
    while (n < 8) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("z_hold_before_exec_end", z_flag, model_z);
      if (n == 2 && !isimm) begin
        check("exec_alu_op", alu_op, op);
        check("exec_alu_ain", alu_ain, a);
        check("exec_alu_bin", alu_bin, b);
      end
      if (poke) begin
        start = 1'b1;
        scramble_fields();
      end
      tick();
      n++;
    end
    check("done_seen", seen, 1);
    check("done_latency", n, isimm ? 0 : 3);
    check("busy_in_wb", busy, 1);
    check("z_at_wb", z_flag, exp_z);
    check("dbg_old_in_wb", dbg_data, model_rf[rd]);
    if (poke) begin
      start = 1'b1;
      scramble_fields();
    end
    tick();
    start = 1'b0;
    check("done_pulse_ends", done, 0);
    check("idle_after_wb", busy, 0);
    if (!nowb) model_rf[rd] = exp_c;
    model_z = exp_z;
    check("wb_value", dbg_data, model_rf[rd]);
    check("z_after", z_flag, model_z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_acc, second_acc, rises;
    logic prev_busy;
    int waited;

    reset_n = 1'b0;
    start   = 1'b0;
    dbg_addr = 3'd0;
    scramble_fields();
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    model_z = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_z", z_flag, 0);
    check("reset_ain", alu_ain, 0);
    check("reset_op", alu_op, 0);
    for (int i = 0; i < 8; i++) check_reg("reset_reg", 3'(i), 16'h0000);
    tick();

    // Immediate loads and the four ALU ops.
    run_cmd(2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0449, 1'b0, 1'b0);
    run_cmd(2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0213, 1'b0, 1'b0);
    check("imm_z_stays_0", z_flag, 0);
    run_cmd(2'd0, 3'd2, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_cmd(2'd1, 3'd3, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_cmd(2'd2, 3'd4, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_cmd(2'd3, 3'd5, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("z_after_mvn", z_flag, 0);
    check_reg("mov_r0", 3'd0, 16'h0449);
    check_reg("mov_r1", 3'd1, 16'h0213);
    check_reg("add_r2", 3'd2, 16'h065C);
    check_reg("sub_r3", 3'd3, 16'h0236);
    check_reg("and_r4", 3'd4, 16'h0001);
    check_reg("mvn_r5", 3'd5, 16'hFDEC);
    tick();

    // Compare (no write-back) and wrap-around subtraction.
    run_cmd(2'd1, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("cmp_z_set", z_flag, 1);
    sweep_regs("cmp_no_write");
    run_cmd(2'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0, 1'b0);
    check("imm_keeps_z", z_flag, 1);
    run_cmd(2'd1, 3'd7, 3'd6, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_reg("wrap_r7", 3'd7, 16'hFDED);
    check("wrap_z", z_flag, 0);
    tick();

    // start pulsed in every busy cycle must be ignored.
    run_cmd(2'd0, 3'd3, 3'd3, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_cmd(2'd0, 3'd5, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 1'b1);
    sweep_regs("poke_regs");

    // start held high: accepts exactly 5 cycles apart.
    start = 1'b1;
    cmd_op = 2'd0; cmd_rd = 3'd2; cmd_rn = 3'd0; cmd_rm = 3'd1;
    cmd_isimm = 1'b0; cmd_imm = 16'h0000; cmd_nowb = 1'b0;
    prev_busy = busy;
    rises = 0; first_acc = 0; second_acc = 0;
    for (int c = 0; c < 20 && rises < 2; c++) begin
      tick();
      if (busy && !prev_busy) begin
        rises++;
        if (rises == 1) first_acc = c;
        else second_acc = c;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("hold_two_accepts", rises, 2);
    check("hold_spacing", second_acc - first_acc, 5);
    waited = 0;
    while (busy && waited < 10) begin
      tick();
      waited++;
    end
    check("hold_drain", busy, 0);
    model_rf[2] = ref_result(2'd0, model_rf[0], model_rf[1]);
    model_z     = (model_rf[2] == 16'h0000);
    sweep_regs("hold_regs");

    // Asynchronous reset during EXEC of ADD R2.
    dbg_addr = 3'd2;
    start = 1'b1;
    cmd_op = 2'd0; cmd_rd = 3'd2; cmd_rn = 3'd0; cmd_rm = 3'd1;
    cmd_isimm = 1'b0; cmd_nowb = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z_flag, 0);
    check("rst_ain", alu_ain, 0);
    check("rst_bin", alu_bin, 0);
    check("rst_op", alu_op, 0);
    check("rst_r2", dbg_data, 16'h0000);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    model_z = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst_no_done", done, 0);
      tick();
    end
    sweep_regs("rst_regs");

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      logic isimm_r;
      isimm_r = ($urandom_range(0, 3) == 0) || (t < 4);
      run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), isimm_r,
              16'($urandom), !isimm_r && ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0));
      if (t % 10 == 9) sweep_regs("rand_regs");
    end
    sweep_regs("final_regs");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
